// File: rtl/sram_line_responder_pkg.sv
// sram_line_responder shared definitions.
// Line geometry, word-address step and FSM encoding.
package sram_line_responder_pkg;

    localparam int WORDS     = 16;
    localparam int WORD_W    = 48;
    localparam int DM_W      = 6;
    localparam int LINE_W    = WORDS * WORD_W;
    localparam int MASK_W    = WORDS * DM_W;
    localparam int IDX_W     = 4;
    localparam int LINE_LSB  = 6;
    localparam int ADDR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [31:0] word_addr(
        input logic [31-LINE_LSB:0] line,
        input logic [IDX_W-1:0]     idx
    );
        return {line, {LINE_LSB{1'b0}}} + 32'(idx) * 32'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/sram_line_responder_if.sv
// Line-side (ws_*) and word-side (sram*) bus bundle.
// slave = responder view, master = requester/controller view.
interface sram_line_responder_if;
    import sram_line_responder_pkg::*;

    logic [31:0]       ws_addr;
    logic [LINE_W-1:0] ws_din;
    logic [MASK_W-1:0] ws_dm;
    logic              ws_stb;
    logic              ws_we;
    logic              ws_ack;
    logic [LINE_W-1:0] ws_dout;

    logic [31:0]       sramAddr;
    logic [WORD_W-1:0] sramInData;
    logic [DM_W-1:0]   sramDm;
    logic              sramStb;
    logic              sramNak;
    logic [WORD_W-1:0] sramOutData;

    modport slave (
        input  ws_addr, ws_din, ws_dm, ws_stb, ws_we,
        input  sramNak, sramOutData,
        output ws_ack, ws_dout,
        output sramAddr, sramInData, sramDm, sramStb
    );

    modport master (
        output ws_addr, ws_din, ws_dm, ws_stb, ws_we,
        output sramNak, sramOutData,
        input  ws_ack, ws_dout,
        input  sramAddr, sramInData, sramDm, sramStb
    );

endinterface

// File: rtl/sram_line_responder.sv
// Serialises one 16x48-bit line request into word accesses
// on the SRAM controller bus and reassembles read lines.
module sram_line_responder
    import sram_line_responder_pkg::*;
(
    input logic                clk,
    input logic                rst,
    sram_line_responder_if.slave bus
);

    state_t state_q, state_d;

    logic [31-LINE_LSB:0] line_q;
    logic [LINE_W-1:0]    din_q;
    logic [MASK_W-1:0]    dm_q;
    logic                 we_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_W-1:0]    dout_q;

    logic [9:0]        word_lsb;
    logic [6:0]        mask_lsb;
    logic [DM_W-1:0]   cur_dm;
    logic [WORD_W-1:0] cur_din;
    logic              in_access;
    logic              skip;
    logic              stb;
    logic              done_word;
    logic              step;
    logic              last;
    logic              accept;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.ws_addr[LINE_LSB-1:0];

    assign word_lsb  = 10'(idx_q) * 10'(WORD_W);
    assign mask_lsb  = 7'(idx_q) * 7'(DM_W);
    assign cur_dm    = dm_q[mask_lsb +: DM_W];
    assign cur_din   = din_q[word_lsb +: WORD_W];
    assign in_access = (state_q == ACCESS);
    // A write word with an empty mask costs a cycle but no bus access.
    assign skip      = in_access & we_q & (cur_dm == '0);
    assign stb       = in_access & ~skip;
    assign done_word = stb & ~bus.sramNak;
    assign step      = skip | done_word;
    assign last      = (idx_q == IDX_W'(WORDS - 1));
    assign accept    = (state_q == IDLE) & bus.ws_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.ws_stb) state_d = ACCESS;
            ACCESS:  if (step && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            din_q  <= '0;
            dm_q   <= '0;
            we_q   <= 1'b0;
            idx_q  <= '0;
            dout_q <= '0;
        end else begin
            if (accept) begin
                line_q <= bus.ws_addr[31:LINE_LSB];
                din_q  <= bus.ws_din;
                dm_q   <= bus.ws_dm;
                we_q   <= bus.ws_we;
                idx_q  <= '0;
            end else if (in_access && step && !last) begin
                idx_q <= idx_q + 1'b1;
            end
            if (done_word && !we_q) begin
                dout_q[word_lsb +: WORD_W] <= bus.sramOutData;
            end
        end
    end

    assign bus.ws_ack     = (state_q == DONE);
    assign bus.ws_dout    = dout_q;
    assign bus.sramStb    = stb;
    assign bus.sramAddr   = word_addr(line_q, idx_q);
    assign bus.sramInData = cur_din;
    assign bus.sramDm     = (in_access && we_q) ? cur_dm : '0;

endmodule
